store_buffer: RTL and testbench
===============================

# store_buffer

Posted-write buffer between the MEM-stage store path and the data memory's single address port. It queues committed stores (sb/sh/sw) in a DEPTH-entry FIFO and drains them into data memory whenever the port is not needed for a load. Loads get priority on the port; a load that hits a word with a pending store is stalled until that store has drained. The data memory's address port doubles as the read address for `mem_RD`, so this block owns that address mux.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥ 2
- AW, 11, byte address width, matching the data memory's 11-bit word/offset address
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- st_valid  in  1  committed store request from MEM stage
- st_ready  out  1  buffer can accept a store this cycle
- st_addr  in  AW  store byte address; [AW-1:2] is the word, [1:0] is the offset
- st_data  in  32  store data, low-aligned (byte in [7:0], half in [15:0])
- st_sel  in  3  000 = byte, 001 = half, 010 = word
- ld_valid  in  1  load request from MEM stage this cycle
- ld_addr  in  AW  load byte address
- ld_stall  out  1  load must be held; the pipeline keeps `ld_valid`/`ld_addr` stable
- dmem_we  out  1  to data memory write enable
- dmem_sel  out  3  to data memory store select
- dmem_addr  out  AW  to data memory address, shared by reads and writes
- dmem_wd  out  32  to data memory write data
- sel_err  out  1  registered one-cycle pulse: an illegal `st_sel` was dropped
- count  out  log2(DEPTH)+1  number of occupied entries
- empty  out  1  count == 0

## Operation
- **Storage and pointers**
  - Each entry holds {addr, data, sel}.
  - Write and read pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - `count` is tracked separately.
- **Accept**
  - `st_ready` = (count != DEPTH), driven from registered state only.
  - A store is accepted on an edge where st_valid && st_ready.
  - An accepted store with legal `st_sel` is written at the write pointer, and the pointer advances.
  - An accepted store with `st_sel` not in {000, 001, 010} is discarded. The pointer and `count` are unchanged, and `sel_err` = 1 in the next cycle.
- **Hazard**
  - ld_stall = ld_valid && (some occupied entry has addr[AW-1:2] == ld_addr[AW-1:2]).
  - This is combinational and compares occupied entries only.
  - A store accepted in the same cycle is not compared. st_valid together with ld_valid is legal; the store is treated as younger than the load.
- **Port arbitration**
  - dmem_we = !empty && (!ld_valid || ld_stall).
  - A stalled load never blocks draining, so a stall always resolves.
  - dmem_addr = (ld_valid && !ld_stall) ? ld_addr : head.addr.
  - dmem_sel = head.sel.
  - dmem_wd = head.data.
  - When `dmem_we` = 0, `dmem_sel` and `dmem_wd` still show the head entry; their values are don't-care.
- **Drain**
  - On an edge where `dmem_we` = 1, the head entry is written to memory and the read pointer advances.
  - Drain order is strict FIFO. Same-word stores are never merged.
- **count update**
  - count += (legal accept) − (drain).
  - Simultaneous accept and drain leaves `count` unchanged.

## Timing
- **Reset (rst_n low, asynchronous)**
  - Pointers = 0, count = 0, empty = 1, st_ready = 1, sel_err = 0.
  - dmem_we = 0 and ld_stall = 0.
  - Entry storage is not reset. Pending stores are lost on reset, including mid-drain.
- **Store latency**
  - Store accepted at edge N into an empty buffer with no load → `dmem_we` = 1 in cycle N+1 → memory written at edge N+1.
- **Throughput**
  - One accept and one drain per cycle, sustained.
  - Full (count == DEPTH) → st_ready = 0 in that cycle. There is no same-cycle pass-through when full.
- **Load stall duration**
  - A hit on the k-th entry from head (k = 1 is head) holds `ld_stall` high for exactly k cycles.
  - On the following cycle `dmem_addr` = ld_addr and `mem_RD` returns the updated word.
- **Load miss**
  - `ld_stall` stays 0 and the drain pauses for that cycle.
  - An empty buffer never stalls a load.
- **Pointer wrap**
  - Wrap-around at DEPTH is seamless.
  - count == DEPTH with equal pointers means full; count == 0 means empty.

## Test plan
- **Single store:** reset, then sw addr 0x010 data 0xDEADBEEF.
  - dmem_we = 1 one cycle later with dmem_addr = 0x010, dmem_sel = 010.
  - count returns to 0; memory word 4 = 0xDEADBEEF.
- **Fill and backpressure:** hold ld_valid = 1 (miss, addr 0x400) and issue 5 stores, DEPTH = 4.
  - st_ready drops after the 4th, count = 4, dmem_we = 0.
  - Release ld_valid: 4 consecutive drains in FIFO order, then st_ready = 1.
- **Load-after-store hit:** buffer sb 0x005 0xAA, sb 0x020 0x11, sh 0x006 0xBEEF; then load 0x004.
  - ld_stall = 1 for 3 cycles.
  - Next cycle mem_RD[31:8] = 0xBEEFAA with the prior byte 0 intact.
- **Simultaneous events:** st_valid with ld_valid to the same word while the buffer is empty.
  - No stall; load reads the old data.
  - Store drains the following cycle.
  - Accept + drain in the same cycle at count 2 keeps count = 2.
- **Illegal select:** st_sel = 011.
  - count unchanged, sel_err pulses once, no memory write.
- **Reset mid-operation:** assert rst_n low with 3 entries pending while dmem_we = 1.
  - All outputs take reset values immediately.
  - No further writes after release.

Source files
------------

// File: rtl/store_buffer.sv
// Posted-write store buffer: queues committed sb/sh/sw stores and drains them into the
// data memory's single address port whenever a load does not need it.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 11
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   st_valid,
  output logic                   st_ready,
  input  logic [AW-1:0]          st_addr,
  input  logic [31:0]            st_data,
  input  logic [2:0]             st_sel,
  input  logic                   ld_valid,
  input  logic [AW-1:0]          ld_addr,
  output logic                   ld_stall,
  output logic                   dmem_we,
  output logic [2:0]             dmem_sel,
  output logic [AW-1:0]          dmem_addr,
  output logic [31:0]            dmem_wd,
  output logic                   sel_err,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [AW-1:0]    addr_q [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [2:0]       sel_q  [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             sel_err_q, sel_err_d;
  logic             accept_s, legal_s, push_s, drain_s, hit_s;
  logic [DEPTH-1:0] occ_s;

  function automatic logic sel_legal(input logic [2:0] sel);
    return (sel == 3'b000) || (sel == 3'b001) || (sel == 3'b010);
  endfunction

  assign st_ready = (count_q != FULL_CNT);
  assign empty    = (count_q == {CW{1'b0}});
  assign count    = count_q;
  assign sel_err  = sel_err_q;

  // Entry i is occupied when its distance from the head is below the occupancy.
  always_comb begin
    occ_s = {DEPTH{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      occ_s[i] = ({1'b0, PW'(i) - rd_ptr_q} < count_q);
    end
  end

  // Word-granular hazard against occupied entries only.
  always_comb begin
    hit_s = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      hit_s = hit_s | (occ_s[i] && (addr_q[i][AW-1:2] == ld_addr[AW-1:2]));
    end
  end

  // Port arbitration: an unstalled load owns the address; otherwise the head drains.
  always_comb begin
    ld_stall  = ld_valid && hit_s;
    dmem_we   = !empty && (!ld_valid || ld_stall);
    dmem_addr = (ld_valid && !ld_stall) ? ld_addr : addr_q[rd_ptr_q];
    dmem_sel  = sel_q[rd_ptr_q];
    dmem_wd   = data_q[rd_ptr_q];
  end

  // Next-state for pointers, occupancy and the illegal-select pulse.
  always_comb begin
    accept_s  = st_valid && st_ready;
    legal_s   = sel_legal(st_sel);
    push_s    = accept_s && legal_s;
    drain_s   = dmem_we;
    sel_err_d = accept_s && !legal_s;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (drain_s) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, drain_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= {PW{1'b0}};
      rd_ptr_q  <= {PW{1'b0}};
      count_q   <= {CW{1'b0}};
      sel_err_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      sel_err_q <= sel_err_d;
    end
  end

  // Entry storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push_s) begin
      addr_q[wr_ptr_q] <= st_addr;
      data_q[wr_ptr_q] <= st_data;
      sel_q[wr_ptr_q]  <= st_sel;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: byte-level memory reference model, queued
// expectations for drains and loads, directed scenarios plus a randomized phase.
module tb_store_buffer;
  localparam int DEPTH = 4;
  localparam int AW    = 11;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        st_valid, ld_valid;
  logic        st_ready, ld_stall, dmem_we, sel_err, empty;
  logic [10:0] st_addr, ld_addr, dmem_addr;
  logic [31:0] st_data, dmem_wd;
  logic [2:0]  st_sel, dmem_sel;
  logic [2:0]  count;

  always #5 clk = ~clk;

  store_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_data(st_data), .st_sel(st_sel),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_stall(ld_stall),
    .dmem_we(dmem_we), .dmem_sel(dmem_sel), .dmem_addr(dmem_addr), .dmem_wd(dmem_wd),
    .sel_err(sel_err), .count(count), .empty(empty)
  );

  typedef struct packed {
    logic [10:0] addr;
    logic [31:0] data;
    logic [2:0]  sel;
  } st_t;

  st_t         st_exp_q[$];
  logic [31:0] ld_exp_q[$];
  logic [7:0]  ref_mem  [2048];
  logic [7:0]  phys_mem [2048];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          occ_exp;
  logic        ld_hold = 1'b0;
  logic        sel_err_exp = 1'b0;
  logic        pushed_now = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic legal(input logic [2:0] s);
    return (s == 3'b000) || (s == 3'b001) || (s == 3'b010);
  endfunction

  function automatic void put(input logic to_phys, input logic [10:0] a, input logic [7:0] d);
    if (to_phys) phys_mem[a] = d;
    else ref_mem[a] = d;
  endfunction

  // Little-endian byte/half/word write into either memory image.
  function automatic void apply(input st_t s, input logic to_phys);
    logic [10:0] b;
    b = {s.addr[10:2], 2'b00};
    case (s.sel)
      3'b000: put(to_phys, s.addr, s.data[7:0]);
      3'b001: begin
        put(to_phys, s.addr, s.data[7:0]);
        put(to_phys, s.addr + 11'd1, s.data[15:8]);
      end
      3'b010: begin
        put(to_phys, b, s.data[7:0]);
        put(to_phys, b + 11'd1, s.data[15:8]);
        put(to_phys, b + 11'd2, s.data[23:16]);
        put(to_phys, b + 11'd3, s.data[31:24]);
      end
      default: ;
    endcase
  endfunction

  function automatic logic [31:0] ref_word(input logic [10:0] a);
    logic [10:0] b;
    b = {a[10:2], 2'b00};
    return {ref_mem[b + 11'd3], ref_mem[b + 11'd2], ref_mem[b + 11'd1], ref_mem[b]};
  endfunction

  function automatic logic [31:0] phys_word(input logic [10:0] a);
    logic [10:0] b;
    b = {a[10:2], 2'b00};
    return {phys_mem[b + 11'd3], phys_mem[b + 11'd2], phys_mem[b + 11'd1], phys_mem[b]};
  endfunction

  function automatic logic pred_hit(input logic [10:0] a);
    logic h;
    h = 1'b0;
    foreach (st_exp_q[i]) if (st_exp_q[i].addr[10:2] == a[10:2]) h = 1'b1;
    return h;
  endfunction

  // One cycle of stimulus, entered and left #1 after a rising edge.
  task automatic tick(input logic sv, input logic [10:0] sa, input logic [31:0] sd,
                      input logic [2:0] ssel, input logic lv, input logic [10:0] la,
                      output logic stalled);
    logic stall_exp, illegal_now;
    st_t  s;
    st_valid = sv; st_addr = sa; st_data = sd; st_sel = ssel;
    ld_valid = lv; ld_addr = la;
    stall_exp = lv && pred_hit(la);
    if (lv && !ld_hold) ld_exp_q.push_back(ref_word(la));
    pushed_now  = 1'b0;
    illegal_now = 1'b0;
    if (sv && (st_exp_q.size() < DEPTH)) begin
      if (legal(ssel)) begin
        s = '{addr: sa, data: sd, sel: ssel};
        st_exp_q.push_back(s);
        apply(s, 1'b0);
        pushed_now = 1'b1;
      end else begin
        illegal_now = 1'b1;
      end
    end
    @(negedge clk);
    stalled = ld_stall;
    check("ld_stall", ld_stall, stall_exp);
    check("sel_err", sel_err, sel_err_exp);
    ld_hold = lv && ld_stall;
    @(posedge clk);
    #1;
    sel_err_exp = illegal_now;
  endtask

  task automatic idle();
    logic stl;
    tick(1'b0, 11'h000, 32'h0, 3'b000, 1'b0, 11'h000, stl);
  endtask

  // Monitor: occupancy, load routing/data and drain order against the queues.
  always @(negedge clk) begin
    if (rst_n) begin
      occ_exp = st_exp_q.size() - (pushed_now ? 1 : 0);
      check("count", count, occ_exp);
      check("empty", empty, occ_exp == 0);
      check("st_ready", st_ready, occ_exp != DEPTH);
      if (ld_valid && !ld_stall) begin
        check("ld_route", dmem_addr, ld_addr);
        if (ld_exp_q.size() == 0) check("unexpected_load", ld_valid, 1'b0);
        else check("ld_data", phys_word(dmem_addr), ld_exp_q.pop_front());
      end
      if (dmem_we) begin
        if (st_exp_q.size() == 0) begin
          check("unexpected_write", dmem_we, 1'b0);
        end else begin
          st_t e;
          e = st_exp_q.pop_front();
          check("wr_addr", dmem_addr, e.addr);
          check("wr_data", dmem_wd, e.data);
          check("wr_sel", dmem_sel, e.sel);
        end
        apply('{addr: dmem_addr, data: dmem_wd, sel: dmem_sel}, 1'b1);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        stl, lv, sv;
    logic [10:0] la, sa;
    logic [2:0]  ssel;
    logic [7:0]  b;
    int          n_stall, hold_run, r;

    rst_n = 1'b0;
    st_valid = 1'b0; st_addr = '0; st_data = '0; st_sel = '0;
    ld_valid = 1'b0; ld_addr = '0;
    for (int i = 0; i < 2048; i++) begin
      b = 8'($urandom);
      ref_mem[i] = b;
      phys_mem[i] = b;
    end
    repeat (2) @(posedge clk);
    #1;
    check("rst_count", count, 0);
    check("rst_empty", empty, 1'b1);
    check("rst_st_ready", st_ready, 1'b1);
    check("rst_dmem_we", dmem_we, 1'b0);
    check("rst_sel_err", sel_err, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single store
    tick(1'b1, 11'h010, 32'hDEADBEEF, 3'b010, 1'b0, 11'h000, stl);
    check("single_we", dmem_we, 1'b1);
    check("single_addr", dmem_addr, 11'h010);
    check("single_sel", dmem_sel, 3'b010);
    idle();
    check("single_count", count, 0);
    check("single_mem", phys_word(11'h010), 32'hDEADBEEF);

    // Fill and backpressure behind a missing load
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, 11'(32'h100 + 4 * i), $urandom, 3'b010, 1'b1, 11'h400, stl);
      if (i == 3) check("fill_ready_after4", st_ready, 1'b0);
    end
    check("fill_ready", st_ready, 1'b0);
    check("fill_count", count, 4);
    check("fill_we", dmem_we, 1'b0);
    repeat (4) idle();
    check("drain_count", count, 0);
    check("drain_ready", st_ready, 1'b1);

    // Load-after-store hit
    tick(1'b1, 11'h004, 32'h12345678, 3'b010, 1'b0, 11'h000, stl);
    idle();
    tick(1'b1, 11'h005, 32'h000000AA, 3'b000, 1'b1, 11'h400, stl);
    tick(1'b1, 11'h020, 32'h00000011, 3'b000, 1'b1, 11'h400, stl);
    tick(1'b1, 11'h006, 32'h0000BEEF, 3'b001, 1'b1, 11'h400, stl);
    n_stall = 0;
    for (int g = 0; g < 10; g++) begin
      tick(1'b0, 11'h000, 32'h0, 3'b000, 1'b1, 11'h004, stl);
      if (stl) n_stall++;
      else break;
    end
    check("hit_stall_cycles", n_stall, 3);
    check("hit_word_hi", phys_word(11'h004) >> 8, 32'h00BEEFAA);
    check("hit_word_lo", phys_word(11'h004) & 32'hFF, 32'h78);

    // Simultaneous store and load to the same word, empty buffer
    tick(1'b1, 11'h008, 32'hCAFEF00D, 3'b010, 1'b1, 11'h008, stl);
    check("simul_no_stall", stl, 1'b0);
    st_valid = 1'b0; ld_valid = 1'b0; pushed_now = 1'b0;
    #1;
    check("simul_drain_we", dmem_we, 1'b1);
    check("simul_drain_addr", dmem_addr, 11'h008);
    idle();
    check("simul_mem", phys_word(11'h008), 32'hCAFEF00D);
    tick(1'b1, 11'h00C, 32'h01020304, 3'b010, 1'b1, 11'h400, stl);
    tick(1'b1, 11'h010, 32'h05060708, 3'b010, 1'b1, 11'h400, stl);
    check("pre_acc_drain_count", count, 2);
    tick(1'b1, 11'h014, 32'h090A0B0C, 3'b010, 1'b0, 11'h000, stl);
    check("acc_drain_count", count, 2);
    repeat (3) idle();

    // Illegal select
    tick(1'b1, 11'h018, 32'h55555555, 3'b011, 1'b0, 11'h000, stl);
    check("illegal_sel_err", sel_err, 1'b1);
    check("illegal_count", count, 0);
    check("illegal_we", dmem_we, 1'b0);
    idle();
    check("illegal_sel_err_clear", sel_err, 1'b0);

    // Reset while draining
    for (int i = 0; i < 3; i++) tick(1'b1, 11'(32'h200 + 4 * i), $urandom, 3'b010, 1'b1, 11'h400, stl);
    st_valid = 1'b0; ld_valid = 1'b0; pushed_now = 1'b0;
    #1;
    check("mid_we_before_rst", dmem_we, 1'b1);
    rst_n = 1'b0;
    #1;
    ld_valid = 1'b1; ld_addr = 11'h200;
    #1;
    check("mid_rst_count", count, 0);
    check("mid_rst_empty", empty, 1'b1);
    check("mid_rst_ready", st_ready, 1'b1);
    check("mid_rst_we", dmem_we, 1'b0);
    check("mid_rst_stall", ld_stall, 1'b0);
    check("mid_rst_sel_err", sel_err, 1'b0);
    ld_valid = 1'b0;
    st_exp_q.delete();
    ld_exp_q.delete();
    for (int i = 0; i < 2048; i++) ref_mem[i] = phys_mem[i];
    ld_hold = 1'b0; sel_err_exp = 1'b0;
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    repeat (4) idle();
    check("post_rst_count", count, 0);

    // Randomized traffic on a small address window to provoke hazards
    hold_run = 0;
    lv = 1'b0; la = 11'h000;
    for (int n = 0; n < 800; n++) begin
      if (!ld_hold) begin
        lv = ($urandom_range(0, 2) == 0);
        la = 11'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
      end
      r = $urandom_range(0, 9);
      ssel = (r < 3) ? 3'b000 : (r < 6) ? 3'b001 : (r < 9) ? 3'b010 : 3'($urandom_range(3, 7));
      sa = 11'($urandom_range(0, 15) * 4);
      if (ssel == 3'b000) sa = sa + 11'($urandom_range(0, 3));
      else if (ssel == 3'b001) sa = sa + 11'($urandom_range(0, 1) * 2);
      sv = ($urandom_range(0, 1) == 1) && !ld_hold && !(lv && pred_hit(la));
      tick(sv, sa, $urandom, ssel, lv, la, stl);
      hold_run = ld_hold ? hold_run + 1 : 0;
      if (hold_run > DEPTH) begin
        check("stall_bound", hold_run, DEPTH);
        ld_hold = 1'b0;
        hold_run = 0;
      end
    end
    repeat (DEPTH + 4) idle();
    check("end_st_queue", st_exp_q.size(), 0);
    check("end_ld_queue", ld_exp_q.size(), 0);
    check("end_count", count, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
